// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared sizes and FSM state encodings for shift_add_mult_4.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH  = 4;
    localparam int ITERS  = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ripple_4_bit.sv
`default_nettype none
// ============================================================================
// Module   : ripple_4_bit
// Brief    : 4-bit ripple-carry adder built from a chain of full adders.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_f,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = c_f;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[4];

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_4.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_4
// Brief    : Sequential 4x4 unsigned shift-and-add multiplier, one adder pass
//            per cycle. Optional running product accumulator: PROD_ACCUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_4
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
`ifdef PROD_ACCUM_EN
    ,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  acc
`endif
);

    localparam logic [1:0] c_cnt_last = 2'(ITERS - 1);

    generate
        if (WIDTH != mult_pkg::WIDTH) begin : g_width_check
            $error("shift_add_mult_4: WIDTH must be 4 to match ripple_4_bit");
        end
        if (ACC_W < PROD_W) begin : g_acc_w_check
            $error("shift_add_mult_4: ACC_W must be at least PROD_W");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mult;
    logic [WIDTH-1:0]    r_acc_hi;
    logic [1:0]          r_cnt;
    logic [PROD_W-1:0]   r_product;

    logic [WIDTH-1:0]    w_addend;
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic [2*WIDTH-1:0]  w_shift;
    logic                w_accept;
    logic                w_last;

    assign w_addend = r_mult[0] ? r_mcand : '0;

    ripple_4_bit u_adder (
        .a    (r_acc_hi),
        .b    (w_addend),
        .c_f  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // {cout,sum,mult} >> 1 with the always-zero MSB dropped
    assign w_shift  = {w_cout, w_sum, r_mult[WIDTH-1:1]};

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign product  = r_product;
    assign w_accept = start && !busy;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_cnt_last);

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_RUN:   w_state_next = (r_cnt == c_cnt_last) ? S_DONE : S_RUN;
            // IDLE, DONE and the unused encoding all accept a new request
            default: w_state_next = w_accept ? S_RUN : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mult    <= '0;
            r_acc_hi  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_mult   <= b;
            r_acc_hi <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_mult} <= w_shift;
            r_cnt              <= r_cnt + 2'd1;
            if (w_last) begin
                r_product <= w_shift;
            end
        end
    end

`ifdef PROD_ACCUM_EN
    logic [ACC_W-1:0] r_acc;

    // A clear coinciding with completion keeps only the new product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr && w_last) begin
            r_acc <= ACC_W'(w_shift);
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_last) begin
            r_acc <= r_acc + ACC_W'(w_shift);
        end
    end

    assign acc = r_acc;
`endif

endmodule
`default_nettype wire

// File: doc/shift_add_mult_4.md
Name: shift_add_mult_4

Overview:
Sequential 4x4 unsigned shift-and-add multiplier. Each iteration it feeds partial-product operands into one ripple_4_bit adder instance and consumes the sum and carry-out, so it sits directly upstream and downstream of that adder. Its purpose is to provide multiply capability to the lab datapath without a combinational array multiplier.

Parameters:
WIDTH, 4, operand width; must be 4 to match ripple_4_bit, otherwise an elaboration error is raised.
ACC_W, 12, accumulator width; used only when PROD_ACCUM_EN is defined.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request; accepted when start=1 and busy=0.
a  input  4  multiplicand, sampled on the accept edge.
b  input  4  multiplier, sampled on the accept edge.
busy  output  1  high while iterating (RUN state).
done  output  1  one-cycle pulse; product is valid and new.
product  output  8  registered result; holds until the next completion.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, product=8'h00, iteration count=0, internal acc/mcand/mult cleared. Applies from any state, including mid-RUN; the in-flight operation is discarded and no done pulse is produced.
- FSM states:
  - IDLE: on start, latch mcand=a, mult=b, acc_hi=4'h0, cnt=0, go to RUN. Otherwise stay.
  - RUN: each cycle, the adder computes acc_hi + (mult[0] ? mcand : 4'h0) with c_f=0, giving {cout,sum}. Then {acc_hi,mult} <= {cout,sum,mult} >> 1, i.e. a 9-bit right shift. cnt++. On the edge where cnt==3, product <= {new acc_hi, new mult} and the state goes to DONE.
  - DONE: done=1 for exactly this cycle. Same-cycle start is accepted (busy=0), which latches new operands and goes to RUN. Otherwise go to IDLE.
- Latency: accept edge E0, then 4 RUN edges (E1..E4). done is high in the cycle after E4, and product updates at E4.
- busy = (state==RUN). start while busy is ignored, with no queuing and no error.
- Arithmetic: unsigned. The result never exceeds 8'hE1, so there is no overflow.
- Inputs a and b are don't-care except on the accept edge.
- Encodings 2'b11 are unreachable; treat as IDLE.

Optional Feature:
Macro PROD_ACCUM_EN.
- Defined: adds input acc_clr (1 bit) and output acc (ACC_W bits, reset 0).
  - On the DONE-entry edge (E4), acc <= acc + zero-extended product, wrapping modulo 2^ACC_W.
  - acc_clr=1 at an edge sets acc <= 0.
  - If acc_clr coincides with E4, acc <= product (clear, then add the new product).
- Undefined: neither port exists, no accumulator logic is generated, and the core timing is identical.

Decomposition:
- Package mult_pkg holds:
  - localparams WIDTH=4, ITERS=4, PROD_W=8.
  - State encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
- One sub-module: the existing ripple_4_bit, instantiated once, c_f tied to 0.
- The FSM, shift register and optional accumulator stay in the top module.

Test Plan:
- Reset, then start with a=4'hF, b=4'hF -> busy high for 4 cycles; done pulses 1 cycle; product=8'hE1.
- a=4'h3, b=4'h5 -> product=8'h0F. Then a=4'h0, b=4'h9 -> product=8'h00, and done still pulses after the same 5-cycle latency.
- Start a=4'h7, b=4'h6; pulse start with a=4'hF, b=4'hF during RUN -> second request ignored; product=8'h2A; exactly one done.
- Back-to-back: hold start=1 with a=4'h2, b=4'h3, then change a/b to 4'hA/4'hB in the DONE cycle -> products 8'h06 then 8'h6E; done pulses 5 cycles apart.
- Start a=4'hF, b=4'hF; rst_n=0 on the 2nd RUN cycle -> busy=0, done=0, product=8'h00, no later done. A new start a=4'h4, b=4'h4 -> 8'h10.
- With PROD_ACCUM_EN: 15*15 twice -> acc=12'h1C2. acc_clr on the next DONE-entry edge of 3*5 -> acc=12'h00F.
